// File: rtl/opsel_mux_hold_if.sv
// Operand-select bus bundle for opsel_mux_hold: direct buses, select, hold capture and outputs.
// The master modport drives requests; the slave modport is the mux itself.
interface opsel_mux_hold_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_IN     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int SEL_W      = 2
);

  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    sel_valid;
  logic                    cap_strobe;
  logic [2:0]              cap_idx;
  logic [WIDTH-1:0]        cap_data;
  logic                    clr_hold;

  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    sel_err;
  logic [HOLD_DEPTH-1:0]   hold_valid;

  modport master (
    output in_bus,
    output sel,
    output sel_valid,
    output cap_strobe,
    output cap_idx,
    output cap_data,
    output clr_hold,
    input  out,
    input  out_valid,
    input  sel_err,
    input  hold_valid
  );

  modport slave (
    input  in_bus,
    input  sel,
    input  sel_valid,
    input  cap_strobe,
    input  cap_idx,
    input  cap_data,
    input  clr_hold,
    output out,
    output out_valid,
    output sel_err,
    output hold_valid
  );

endinterface

// File: rtl/opsel_mux_hold.sv
// Registered operand mux: NUM_IN direct buses plus a bank of HOLD_DEPTH edge-captured hold slots.
// Optional macro OPSEL_CAP_FWD_EN forwards a same-cycle capture straight to a select of that slot.
module opsel_mux_hold #(
  parameter int WIDTH      = 16,
  parameter int NUM_IN     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int SEL_W      = 2
) (
  input logic               clk,
  input logic               rst,
  opsel_mux_hold_if.slave   bus
);

  localparam int NUM_SRC = NUM_IN + HOLD_DEPTH;

  logic                  cap_q;
  logic [WIDTH-1:0]      slot_q [HOLD_DEPTH];
  logic [WIDTH-1:0]      slot_d [HOLD_DEPTH];
  logic [HOLD_DEPTH-1:0] holdValid_q;
  logic [HOLD_DEPTH-1:0] holdValid_d;
  logic [WIDTH-1:0]      out_q;
  logic [WIDTH-1:0]      out_d;
  logic                  outValid_q;
  logic                  outValid_d;
  logic                  selErr_q;
  logic                  selErr_d;

  logic [31:0]           selNum;
  logic [31:0]           capNum;
  logic                  capRise;
  logic                  capHit;
  logic                  selDirect;
  logic                  selHold;
  logic [WIDTH-1:0]      directVal;
  logic [WIDTH-1:0]      slotVal;
  logic                  slotOk;

  // Widen select and capture index once so every range test is a plain unsigned compare.
  always_comb begin
    selNum    = 32'(bus.sel);
    capNum    = 32'(bus.cap_idx);
    capRise   = bus.cap_strobe & ~cap_q;
    capHit    = capRise && (capNum < 32'(HOLD_DEPTH));
    selDirect = selNum < 32'(NUM_IN);
    selHold   = !selDirect && (selNum < 32'(NUM_SRC));
  end

  always_comb begin
    directVal = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (selNum == 32'(k)) begin
        directVal = bus.in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Slot read sees the registered value unless forwarding lets a same-cycle capture bypass it.
  always_comb begin
    slotVal = '0;
    slotOk  = 1'b0;
    for (int h = 0; h < HOLD_DEPTH; h++) begin
      if (selNum == 32'(NUM_IN + h)) begin
        slotVal = slot_q[h];
        slotOk  = holdValid_q[h];
`ifdef OPSEL_CAP_FWD_EN
        if (capHit && (capNum == 32'(h))) begin
          slotVal = bus.cap_data;
          slotOk  = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    out_d      = out_q;
    outValid_d = 1'b0;
    selErr_d   = 1'b0;
    if (bus.sel_valid) begin
      if (selDirect) begin
        out_d      = directVal;
        outValid_d = 1'b1;
      end else if (selHold) begin
        out_d      = slotOk ? slotVal : '0;
        outValid_d = 1'b1;
        selErr_d   = ~slotOk;
      end else begin
        selErr_d   = 1'b1;
      end
    end
  end

  // Clear is applied first so a capture in the same cycle leaves its slot flagged valid.
  always_comb begin
    holdValid_d = bus.clr_hold ? '0 : holdValid_q;
    for (int h = 0; h < HOLD_DEPTH; h++) begin
      slot_d[h] = slot_q[h];
      if (capHit && (capNum == 32'(h))) begin
        slot_d[h]      = bus.cap_data;
        holdValid_d[h] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= 1'b0;
      holdValid_q <= '0;
      out_q       <= '0;
      outValid_q  <= 1'b0;
      selErr_q    <= 1'b0;
      for (int h = 0; h < HOLD_DEPTH; h++) begin
        slot_q[h] <= '0;
      end
    end else begin
      cap_q       <= bus.cap_strobe;
      holdValid_q <= holdValid_d;
      out_q       <= out_d;
      outValid_q  <= outValid_d;
      selErr_q    <= selErr_d;
      for (int h = 0; h < HOLD_DEPTH; h++) begin
        slot_q[h] <= slot_d[h];
      end
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = outValid_q;
  assign bus.sel_err    = selErr_q;
  assign bus.hold_valid = holdValid_q;

endmodule

// File: tb/tb_opsel_mux_hold.sv
// Bench for opsel_mux_hold: default build (A) and a 3-input build (B) share one stimulus stream,
// each checked every cycle against a behavioural model, plus fixed expectations at key points.
module tb_opsel_mux_hold;

  typedef struct packed {
    logic        rst;
    logic [47:0] inBus;
    logic [2:0]  sel;
    logic        selValid;
    logic        capStrobe;
    logic [2:0]  capIdx;
    logic [15:0] capData;
    logic        clrHold;
  } stim_t;

  typedef struct packed {
    logic [15:0]      out;
    logic             outValid;
    logic             selErr;
    logic [1:0]       holdValid;
    logic [1:0][15:0] slot;
    logic             capQ;
  } model_t;

  logic   clk;
  logic   rst;
  stim_t  st;
  model_t mA;
  model_t mB;
  int     testCount;
  int     failCount;

  opsel_mux_hold_if #(.WIDTH(16), .NUM_IN(2), .HOLD_DEPTH(2), .SEL_W(2)) ifA ();
  opsel_mux_hold_if #(.WIDTH(16), .NUM_IN(3), .HOLD_DEPTH(2), .SEL_W(3)) ifB ();

  opsel_mux_hold #(.WIDTH(16), .NUM_IN(2), .HOLD_DEPTH(2), .SEL_W(2)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  opsel_mux_hold #(.WIDTH(16), .NUM_IN(3), .HOLD_DEPTH(2), .SEL_W(3)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of the operand mux described from its rules: sources numbered direct first, then slots.
  function automatic model_t modelStep(input model_t m, input stim_t s, input int numIn, input int selBits);
    model_t      n;
    int          selNum;
    int          slotNum;
    logic        rise;
    logic        slotOk;
    logic [15:0] slotData;
    n = m;
    if (s.rst) begin
      n = '0;
      return n;
    end
    rise   = s.capStrobe && !m.capQ;
    selNum = (selBits == 2) ? int'(s.sel[1:0]) : int'(s.sel);
    if (!s.selValid) begin
      n.outValid = 1'b0;
      n.selErr   = 1'b0;
    end else if (selNum < numIn) begin
      n.out      = s.inBus[selNum*16 +: 16];
      n.outValid = 1'b1;
      n.selErr   = 1'b0;
    end else if (selNum < numIn + 2) begin
      slotNum  = selNum - numIn;
      slotOk   = m.holdValid[slotNum];
      slotData = m.slot[slotNum];
`ifdef OPSEL_CAP_FWD_EN
      if (rise && int'(s.capIdx) == slotNum) begin
        slotOk   = 1'b1;
        slotData = s.capData;
      end
`endif
      n.out      = slotOk ? slotData : 16'h0000;
      n.outValid = 1'b1;
      n.selErr   = !slotOk;
    end else begin
      n.outValid = 1'b0;
      n.selErr   = 1'b1;
    end
    if (s.clrHold) n.holdValid = 2'b00;
    if (rise && s.capIdx < 3'd2) begin
      n.slot[s.capIdx[0]]      = s.capData;
      n.holdValid[s.capIdx[0]] = 1'b1;
    end
    n.capQ = s.capStrobe;
    return n;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("A.out",        32'(ifA.out),        32'(mA.out));
    checkVal("A.out_valid",  32'(ifA.out_valid),  32'(mA.outValid));
    checkVal("A.sel_err",    32'(ifA.sel_err),    32'(mA.selErr));
    checkVal("A.hold_valid", 32'(ifA.hold_valid), 32'(mA.holdValid));
    checkVal("B.out",        32'(ifB.out),        32'(mB.out));
    checkVal("B.out_valid",  32'(ifB.out_valid),  32'(mB.outValid));
    checkVal("B.sel_err",    32'(ifB.sel_err),    32'(mB.selErr));
    checkVal("B.hold_valid", 32'(ifB.hold_valid), 32'(mB.holdValid));
  endtask

  // Drive the current stimulus, let one edge pass, then advance the models and compare.
  task automatic applyStimulus();
    rst            = st.rst;
    ifA.in_bus     = st.inBus[31:0];
    ifB.in_bus     = st.inBus;
    ifA.sel        = st.sel[1:0];
    ifB.sel        = st.sel;
    ifA.sel_valid  = st.selValid;
    ifB.sel_valid  = st.selValid;
    ifA.cap_strobe = st.capStrobe;
    ifB.cap_strobe = st.capStrobe;
    ifA.cap_idx    = st.capIdx;
    ifB.cap_idx    = st.capIdx;
    ifA.cap_data   = st.capData;
    ifB.cap_data   = st.capData;
    ifA.clr_hold   = st.clrHold;
    ifB.clr_hold   = st.clrHold;
    @(posedge clk);
    #1;
    mA = modelStep(mA, st, 2, 2);
    mB = modelStep(mB, st, 3, 3);
    checkOutput();
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    mA = '0;
    mB = '0;
    st = '0;

    st.rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkVal("reset.out", 32'(ifA.out), 32'h0);
    checkVal("reset.hold_valid", 32'(ifA.hold_valid), 32'h0);

    st = '0;
    st.selValid     = 1'b1;
    st.inBus[15:0]  = 16'h1234;
    applyStimulus();
    checkVal("direct0.out", 32'(ifA.out), 32'h1234);
    checkVal("direct0.valid", 32'(ifA.out_valid), 32'h1);

    st = '0;
    st.capStrobe = 1'b1;
    st.capData   = 16'hBEEF;
    applyStimulus();
    st.capData   = 16'h0000;
    for (int i = 0; i < 3; i++) applyStimulus();
    st.capStrobe = 1'b0;
    st.selValid  = 1'b1;
    st.sel       = 3'd2;
    applyStimulus();
    checkVal("heldcap.out", 32'(ifA.out), 32'hBEEF);
    checkVal("heldcap.hold_valid", 32'(ifA.hold_valid), 32'h1);

    st = '0;
    st.rst = 1'b1;
    applyStimulus();
    st.rst      = 1'b0;
    st.selValid = 1'b1;
    st.sel      = 3'd3;
    applyStimulus();
    checkVal("unwritten.out", 32'(ifA.out), 32'h0);
    checkVal("unwritten.valid", 32'(ifA.out_valid), 32'h1);
    checkVal("unwritten.err", 32'(ifA.sel_err), 32'h1);
    st.selValid  = 1'b0;
    st.capStrobe = 1'b1;
    st.capIdx    = 3'd1;
    st.capData   = 16'h5555;
    applyStimulus();
    checkVal("errpulse.err", 32'(ifA.sel_err), 32'h0);
    st.capStrobe = 1'b0;
    st.clrHold   = 1'b1;
    applyStimulus();
    st.clrHold   = 1'b0;
    st.selValid  = 1'b1;
    st.sel       = 3'd3;
    applyStimulus();
    checkVal("cleared.err", 32'(ifA.sel_err), 32'h1);

    st = '0;
    st.selValid    = 1'b1;
    st.inBus[15:0] = 16'h00AA;
    applyStimulus();
    st.sel = 3'd6;
    applyStimulus();
    checkVal("oor.out", 32'(ifB.out), 32'h00AA);
    checkVal("oor.valid", 32'(ifB.out_valid), 32'h0);
    checkVal("oor.err", 32'(ifB.sel_err), 32'h1);

    st = '0;
    st.capStrobe = 1'b1;
    st.capData   = 16'h1111;
    applyStimulus();
    st.capStrobe = 1'b0;
    applyStimulus();
    st.capStrobe = 1'b1;
    st.capData   = 16'h2222;
    st.selValid  = 1'b1;
    st.sel       = 3'd2;
    applyStimulus();
`ifdef OPSEL_CAP_FWD_EN
    checkVal("samecycle.out", 32'(ifA.out), 32'h2222);
`else
    checkVal("samecycle.out", 32'(ifA.out), 32'h1111);
`endif
    applyStimulus();
    checkVal("nextcycle.out", 32'(ifA.out), 32'h2222);

    st = '0;
    applyStimulus();
    st.rst       = 1'b1;
    st.capStrobe = 1'b1;
    st.capData   = 16'h7777;
    applyStimulus();
    st = '0;
    st.selValid = 1'b1;
    st.sel      = 3'd2;
    applyStimulus();
    checkVal("rstcap.out", 32'(ifA.out), 32'h0);
    checkVal("rstcap.hold_valid", 32'(ifA.hold_valid), 32'h0);

    for (int i = 0; i < 400; i++) begin
      st.rst       = ($urandom_range(0, 31) == 0);
      st.inBus     = {16'($urandom), 32'($urandom)};
      st.sel       = 3'($urandom);
      st.selValid  = ($urandom_range(0, 3) != 0);
      st.capStrobe = 1'($urandom);
      st.capIdx    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      st.capData   = 16'($urandom);
      st.clrHold   = ($urandom_range(0, 15) == 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/opsel_mux_hold.md
Name: opsel_mux_hold

Overview:
- Parametrised, clocked successor to the SISC 16-bit operand mux.
- Selects one of NUM_IN direct operand buses or one of HOLD_DEPTH captured hold registers (the Rs hold slot generalised to a bank), with a registered output and valid/error flags.
- Hold capture is edge-detected inside the clock domain; no signal other than clk drives a clock pin.
- Sits between the register file and the ALU operand port.

Parameters:
- WIDTH, 16, data width of every input, hold slot and output.
- NUM_IN, 2, number of direct inputs. Legal range is 1..8.
- HOLD_DEPTH, 2, number of hold slots. Legal range is 1..8.
- SEL_W, 2, select width. Must satisfy 2**SEL_W >= NUM_IN+HOLD_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_bus  in  NUM_IN*WIDTH  direct inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  source select.
- sel_valid  in  1  qualifies sel for this cycle.
- cap_strobe  in  1  capture request; acts on its rising edge only.
- cap_idx  in  3  target hold slot for the capture.
- cap_data  in  WIDTH  value to capture.
- clr_hold  in  1  clears all hold-valid flags.
- out  out  WIDTH  registered selected operand.
- out_valid  out  1  out was updated by a valid select in the previous cycle.
- sel_err  out  1  one-cycle pulse: unwritten slot or out-of-range select.
- hold_valid  out  HOLD_DEPTH  per-slot written flag.

Behaviour:
- Clock and reset:
  - One clock, clk; reset rst is synchronous and active-high.
  - Reset values: out=0, out_valid=0, sel_err=0, hold_valid=0, all slots=0, strobe history register cap_q=0.
- Capture edge detection:
  - cap_q <= cap_strobe every cycle; rise = cap_strobe & ~cap_q.
  - Strobe held high captures once only.
  - Strobe already high on the first cycle after reset counts as a rise.
- Capture:
  - On rise with cap_idx < HOLD_DEPTH: slot[cap_idx] <= cap_data and hold_valid[cap_idx] <= 1.
  - cap_idx >= HOLD_DEPTH: ignored, no flag.
- Clear:
  - clr_hold=1 sets hold_valid <= 0; slot data is retained.
  - If a capture happens in the same cycle, the captured slot's flag ends at 1 (capture wins).
- Select decode (evaluated when sel_valid=1):
  - sel < NUM_IN: source is direct input sel.
  - NUM_IN <= sel < NUM_IN+HOLD_DEPTH: source is slot s = sel-NUM_IN.
  - sel >= NUM_IN+HOLD_DEPTH: out-of-range.
- Output stage (latency 1 cycle):
  - sel_valid=1, legal source: out <= source, out_valid <= 1, sel_err <= 0.
  - Hold slot selected with hold_valid[s]=0: out <= 0, out_valid <= 1, sel_err <= 1.
  - Out-of-range: out holds its previous value, out_valid <= 0, sel_err <= 1.
  - sel_valid=0: out holds, out_valid <= 0, sel_err <= 0.
- Same-cycle capture and select of the same slot:
  - out receives the pre-capture slot value; hold_valid is also the pre-capture value (see Optional Feature).
- Reset mid-operation: all state returns to reset values next edge; a capture in that cycle is lost.
- Defaults (NUM_IN=2, HOLD_DEPTH=2) map as:
  - sel 0,1: direct inputs.
  - sel 2: Rs hold slot 0.
  - sel 3: hold slot 1.

Optional Feature:
- Macro: OPSEL_CAP_FWD_EN.
- Defined: capture-to-select forwarding.
  - If rise and sel_valid target the same slot in one cycle, out <= cap_data and the unwritten check treats the slot as valid.
  - The result is a zero-bubble Rs update.
- Undefined: registered-value behaviour exactly as stated in Behaviour.

Test Plan:
- Reset, then sel_valid=1, sel=0, in_bus[15:0]=16'h1234 -> next cycle out=16'h1234, out_valid=1, sel_err=0.
- cap_strobe 0->1 held 4 cycles, cap_idx=0, cap_data=16'hBEEF, then sel=2 -> out=16'hBEEF, hold_valid=2'b01, one capture only (change cap_data mid-hold to 16'h0000; out stays 16'hBEEF).
- Reset, sel=3 -> out=0, out_valid=1, sel_err pulses 1 for one cycle. Then clr_hold after capturing slot1, sel=3 -> sel_err=1.
- NUM_IN=3, HOLD_DEPTH=2, SEL_W=3, sel=6 -> out holds prior value 16'h00AA, out_valid=0, sel_err=1.
- Slot0=16'h1111; same cycle cap rise cap_idx=0 cap_data=16'h2222 and sel=2 -> out=16'h1111 without macro, out=16'h2222 with OPSEL_CAP_FWD_EN. The following cycle with sel=2 -> 16'h2222 in both builds.
- rst asserted the same cycle as a capture rise -> slot stays 0, hold_valid=0, out=0.
